// File: rtl/cp0_exception_unit_pkg.sv
// Shared CP0 definitions: register numbers, exception codes,
// Status/Cause bit layout and reset values.
package cp0_exception_unit_pkg;

    localparam logic [4:0] REG_BADVADDR = 5'd8;
    localparam logic [4:0] REG_COUNT    = 5'd9;
    localparam logic [4:0] REG_COMPARE  = 5'd11;
    localparam logic [4:0] REG_STATUS   = 5'd12;
    localparam logic [4:0] REG_CAUSE    = 5'd13;
    localparam logic [4:0] REG_EPC      = 5'd14;

    localparam logic [31:0] STATUS_RST = 32'h0040_0000;

    typedef enum logic [4:0] {
        EXC_INT  = 5'd0,
        EXC_ADEL = 5'd4,
        EXC_ADES = 5'd5,
        EXC_SYS  = 5'd8,
        EXC_BP   = 5'd9,
        EXC_RI   = 5'd10,
        EXC_OV   = 5'd12
    } exc_code_e;

    typedef struct packed {
        logic      hit;
        exc_code_e code;
        logic      bad_pc;
        logic      bad_mem;
    } exc_sel_t;

    // BEV (bit 22) is hard-wired to 1.
    function automatic logic [31:0] pack_status(
        input logic [7:0] im,
        input logic       exl,
        input logic       ie
    );
        return {9'b0, 1'b1, 6'b0, im, 6'b0, exl, ie};
    endfunction

    function automatic logic [31:0] pack_cause(
        input logic       bd,
        input logic       ti,
        input logic [5:0] ip_hw,
        input logic [1:0] ip_sw,
        input exc_code_e  code
    );
        return {bd, ti, 14'b0, ip_hw, ip_sw, 1'b0, code, 2'b0};
    endfunction

endpackage

// File: rtl/cp0_exception_unit_if.sv
// Commit-stage bundle between the control unit and CP0.
interface cp0_exception_unit_if;

    logic        commit_valid;
    logic        cp0_Write;
    logic        mfc0;
    logic        eret;
    logic        sys;
    logic        bp;
    logic        ri;
    logic        ov;
    logic        adel_if;
    logic        adel_mem;
    logic        ades;
    logic        is_delay_slot;
    logic [4:0]  cp0_addr;
    logic [31:0] cp0_wdata;
    logic [31:0] pc;
    logic [31:0] mem_vaddr;
    logic [5:0]  hw_int;
    logic [31:0] cp0_rdata;
    logic        exc_flush;
    logic [31:0] exc_target;
    logic        int_pending;

    modport master (
        output commit_valid, cp0_Write, mfc0, eret,
        output sys, bp, ri, ov, adel_if, adel_mem, ades,
        output is_delay_slot, cp0_addr, cp0_wdata,
        output pc, mem_vaddr, hw_int,
        input  cp0_rdata, exc_flush, exc_target, int_pending
    );

    modport slave (
        input  commit_valid, cp0_Write, mfc0, eret,
        input  sys, bp, ri, ov, adel_if, adel_mem, ades,
        input  is_delay_slot, cp0_addr, cp0_wdata,
        input  pc, mem_vaddr, hw_int,
        output cp0_rdata, exc_flush, exc_target, int_pending
    );

endinterface

// File: rtl/cp0_exception_unit_timer.sv
// Count/Compare timer: prescaled Count, Compare match raises TI
// until software rewrites Compare.
module cp0_exception_unit_timer #(
    parameter int COUNT_DIV_LOG2 = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        count_we,
    input  logic        compare_we,
    input  logic [31:0] wdata,
    output logic [31:0] count,
    output logic [31:0] compare,
    output logic        ti
);

    localparam int DW = (COUNT_DIV_LOG2 > 0) ? COUNT_DIV_LOG2 : 1;

    logic [DW-1:0] div_q;
    logic          tick;

    assign tick = (COUNT_DIV_LOG2 == 0) ? 1'b1 : &div_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            div_q   <= '0;
            count   <= '0;
            compare <= '0;
            ti      <= 1'b0;
        end else begin
            div_q <= div_q + DW'(1);
            if (count_we) begin
                count <= wdata;
            end else if (tick) begin
                count <= count + 32'd1;
            end
            // A Compare write acknowledges the interrupt and masks a same-cycle match.
            if (compare_we) begin
                compare <= wdata;
                ti      <= 1'b0;
            end else if (count == compare) begin
                ti <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/cp0_exception_unit.sv
// CP0 register file and commit-stage exception/interrupt responder
// with pipeline flush and redirect.
module cp0_exception_unit
    import cp0_exception_unit_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR     = 32'hBFC0_0380,
    parameter int          COUNT_DIV_LOG2 = 1
) (
    input logic                 clk,
    input logic                 rst,
    cp0_exception_unit_if.slave bus
);

    logic        rst_q;
    logic        live;
    logic        commit;
    logic [7:0]  im;
    logic        exl;
    logic        ie;
    logic        bd;
    logic [5:0]  ip_hw;
    logic [1:0]  ip_sw;
    exc_code_e   code;
    logic [31:0] epc;
    logic [31:0] badvaddr;
    logic [31:0] count;
    logic [31:0] compare;
    logic        ti;
    logic        int_req;
    exc_sel_t    sel;
    logic        exc_take;
    logic        eret_take;
    logic        wr_take;
    logic [31:0] rd_mux;

    // Outputs stay quiet during reset and the cycle that follows it.
    always_ff @(posedge clk) begin
        rst_q <= rst;
    end

    assign live    = ~rst & ~rst_q;
    assign commit  = bus.commit_valid & live;
    assign int_req = ie & ~exl & |({ip_hw, ip_sw} & im);

    always_comb begin
        sel      = '0;
        sel.code = EXC_INT;
        sel.hit  = 1'b1;
        if (int_req) begin
            sel.code = EXC_INT;
        end else if (bus.adel_if) begin
            sel.code   = EXC_ADEL;
            sel.bad_pc = 1'b1;
        end else if (bus.ri) begin
            sel.code = EXC_RI;
        end else if (bus.ov) begin
            sel.code = EXC_OV;
        end else if (bus.sys) begin
            sel.code = EXC_SYS;
        end else if (bus.bp) begin
            sel.code = EXC_BP;
        end else if (bus.adel_mem) begin
            sel.code    = EXC_ADEL;
            sel.bad_mem = 1'b1;
        end else if (bus.ades) begin
            sel.code    = EXC_ADES;
            sel.bad_mem = 1'b1;
        end else begin
            sel.hit = 1'b0;
        end
    end

    assign exc_take  = commit & sel.hit;
    assign eret_take = commit & bus.eret & ~exc_take;
    assign wr_take   = commit & bus.cp0_Write & ~exc_take & ~bus.eret;

    cp0_exception_unit_timer #(
        .COUNT_DIV_LOG2(COUNT_DIV_LOG2)
    ) u_timer (
        .clk       (clk),
        .rst       (rst),
        .count_we  (wr_take & (bus.cp0_addr == REG_COUNT)),
        .compare_we(wr_take & (bus.cp0_addr == REG_COMPARE)),
        .wdata     (bus.cp0_wdata),
        .count     (count),
        .compare   (compare),
        .ti        (ti)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            im       <= '0;
            exl      <= 1'b0;
            ie       <= 1'b0;
            bd       <= 1'b0;
            ip_hw    <= '0;
            ip_sw    <= '0;
            code     <= EXC_INT;
            epc      <= '0;
            badvaddr <= '0;
        end else begin
            ip_hw <= {bus.hw_int[5] | ti, bus.hw_int[4:0]};
            if (exc_take) begin
                code <= sel.code;
                exl  <= 1'b1;
                // A nested exception keeps the original return point.
                if (!exl) begin
                    epc <= bus.is_delay_slot ? bus.pc - 32'd4 : bus.pc;
                    bd  <= bus.is_delay_slot;
                end
                if (sel.bad_pc) begin
                    badvaddr <= bus.pc;
                end else if (sel.bad_mem) begin
                    badvaddr <= bus.mem_vaddr;
                end
            end else if (eret_take) begin
                exl <= 1'b0;
            end else if (wr_take) begin
                if (bus.cp0_addr == REG_STATUS) begin
                    im  <= bus.cp0_wdata[15:8];
                    exl <= bus.cp0_wdata[1];
                    ie  <= bus.cp0_wdata[0];
                end
                if (bus.cp0_addr == REG_CAUSE) begin
                    ip_sw <= bus.cp0_wdata[9:8];
                end
                if (bus.cp0_addr == REG_EPC) begin
                    epc <= bus.cp0_wdata;
                end
            end
        end
    end

    always_comb begin
        rd_mux = '0;
        unique case (bus.cp0_addr)
            REG_BADVADDR: rd_mux = badvaddr;
            REG_COUNT:    rd_mux = count;
            REG_COMPARE:  rd_mux = compare;
            REG_STATUS:   rd_mux = pack_status(im, exl, ie);
            REG_CAUSE:    rd_mux = pack_cause(bd, ti, ip_hw, ip_sw, code);
            REG_EPC:      rd_mux = epc;
            default:      rd_mux = '0;
        endcase
    end

    assign bus.cp0_rdata   = (bus.mfc0 & live) ? rd_mux : '0;
    assign bus.exc_flush   = exc_take | eret_take;
    assign bus.exc_target  = exc_take  ? EXC_VECTOR :
                             eret_take ? epc : '0;
    assign bus.int_pending = live & int_req;

endmodule

// File: tb/tb_cp0_exception_unit.sv
// Directed bench for cp0_exception_unit: reset, priority, eret,
// nesting, timer interrupt and mtc0 corner cases.
module tb_cp0_exception_unit;

    logic clk = 1'b0;
    logic rst;
    int   vectors = 0;
    int   miscompares = 0;
    logic [31:0] v;

    cp0_exception_unit_if bus ();

    cp0_exception_unit dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic idle();
        bus.commit_valid  = 1'b0;
        bus.cp0_Write     = 1'b0;
        bus.mfc0          = 1'b0;
        bus.eret          = 1'b0;
        bus.sys           = 1'b0;
        bus.bp            = 1'b0;
        bus.ri            = 1'b0;
        bus.ov            = 1'b0;
        bus.adel_if       = 1'b0;
        bus.adel_mem      = 1'b0;
        bus.ades          = 1'b0;
        bus.is_delay_slot = 1'b0;
        bus.cp0_addr      = '0;
        bus.cp0_wdata     = '0;
        bus.mem_vaddr     = '0;
        bus.hw_int        = '0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic rdreg(input logic [4:0] a, output logic [31:0] val);
        bus.mfc0     = 1'b1;
        bus.cp0_addr = a;
        #1;
        val = bus.cp0_rdata;
        bus.mfc0 = 1'b0;
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
        idle();
        bus.commit_valid = 1'b1;
        bus.cp0_Write    = 1'b1;
        bus.cp0_addr     = a;
        bus.cp0_wdata    = d;
        cyc();
        idle();
    endtask

    initial begin
        idle();
        bus.pc = '0;
        rst = 1'b1;
        repeat (2) cyc();
        bus.commit_valid = 1'b1;
        bus.sys = 1'b1;
        rdreg(5'd12, v);
        chk("rst_rdata", v, 32'h0);
        chk("rst_flush", {31'b0, bus.exc_flush}, 32'h0);
        cyc();
        rst = 1'b0;
        rdreg(5'd12, v);
        chk("post_rst_rdata", v, 32'h0);
        chk("post_rst_flush", {31'b0, bus.exc_flush}, 32'h0);
        cyc();
        idle();
        rdreg(5'd12, v);
        chk("status_reset", v, 32'h0040_0000);
        rdreg(5'd14, v);
        chk("epc_reset", v, 32'h0);
        chk("int_pending_reset", {31'b0, bus.int_pending}, 32'h0);

        // syscall
        bus.commit_valid = 1'b1;
        bus.sys = 1'b1;
        bus.pc = 32'h8000_0100;
        #1;
        chk("sys_flush", {31'b0, bus.exc_flush}, 32'h1);
        chk("sys_target", bus.exc_target, 32'hBFC0_0380);
        cyc();
        idle();
        rdreg(5'd14, v);
        chk("sys_epc", v, 32'h8000_0100);
        rdreg(5'd13, v);
        chk("sys_exccode", {27'b0, v[6:2]}, 32'd8);
        rdreg(5'd12, v);
        chk("sys_status", v, 32'h0040_0002);

        // eret back to the syscall
        bus.commit_valid = 1'b1;
        bus.eret = 1'b1;
        #1;
        chk("eret1_flush", {31'b0, bus.exc_flush}, 32'h1);
        chk("eret1_target", bus.exc_target, 32'h8000_0100);
        cyc();
        idle();

        // ri + ov + sys in a delay slot
        bus.commit_valid = 1'b1;
        bus.ri = 1'b1;
        bus.ov = 1'b1;
        bus.sys = 1'b1;
        bus.is_delay_slot = 1'b1;
        bus.pc = 32'h8000_0204;
        cyc();
        idle();
        rdreg(5'd13, v);
        chk("prio_exccode", {27'b0, v[6:2]}, 32'd10);
        chk("prio_bd", {31'b0, v[31]}, 32'h1);
        rdreg(5'd14, v);
        chk("prio_epc", v, 32'h8000_0200);

        bus.commit_valid = 1'b1;
        bus.eret = 1'b1;
        #1;
        chk("eret2_target", bus.exc_target, 32'h8000_0200);
        cyc();
        idle();
        rdreg(5'd12, v);
        chk("eret2_status", v, 32'h0040_0000);

        // eret loses to bp
        bus.commit_valid = 1'b1;
        bus.eret = 1'b1;
        bus.bp = 1'b1;
        bus.pc = 32'h8000_0300;
        #1;
        chk("eret_bp_target", bus.exc_target, 32'hBFC0_0380);
        cyc();
        idle();
        rdreg(5'd13, v);
        chk("eret_bp_exccode", {27'b0, v[6:2]}, 32'd9);
        chk("eret_bp_bd", {31'b0, v[31]}, 32'h0);
        rdreg(5'd14, v);
        chk("eret_bp_epc", v, 32'h8000_0300);

        // nested adel_mem while EXL=1
        bus.commit_valid = 1'b1;
        bus.adel_mem = 1'b1;
        bus.mem_vaddr = 32'h8000_0003;
        bus.pc = 32'h8000_0400;
        cyc();
        idle();
        rdreg(5'd8, v);
        chk("adel_badvaddr", v, 32'h8000_0003);
        rdreg(5'd13, v);
        chk("adel_exccode", {27'b0, v[6:2]}, 32'd4);
        rdreg(5'd14, v);
        chk("adel_epc_kept", v, 32'h8000_0300);

        // ov drops a same-cycle mtc0 EPC
        bus.commit_valid = 1'b1;
        bus.ov = 1'b1;
        bus.cp0_Write = 1'b1;
        bus.cp0_addr = 5'd14;
        bus.cp0_wdata = 32'h1234_5678;
        cyc();
        idle();
        rdreg(5'd14, v);
        chk("ov_mtc0_dropped", v, 32'h8000_0300);
        rdreg(5'd13, v);
        chk("ov_exccode", {27'b0, v[6:2]}, 32'd12);

        bus.commit_valid = 1'b1;
        bus.eret = 1'b1;
        cyc();
        idle();

        // timer interrupt
        mtc0(5'd9, 32'h0);
        mtc0(5'd11, 32'd5);
        mtc0(5'd12, 32'h0000_8001);
        rdreg(5'd12, v);
        chk("status_ie_im7", v, 32'h0040_8001);
        chk("int_pending_early", {31'b0, bus.int_pending}, 32'h0);
        for (int i = 0; i < 40 && !bus.int_pending; i++) cyc();
        chk("timer_int_pending", {31'b0, bus.int_pending}, 32'h1);
        rdreg(5'd13, v);
        chk("timer_ti", {31'b0, v[30]}, 32'h1);
        chk("timer_ip7", {31'b0, v[15]}, 32'h1);
        rdreg(5'd9, v);
        chk("timer_count_ge5", {31'b0, (v >= 32'd5)}, 32'h1);

        bus.commit_valid = 1'b1;
        bus.pc = 32'h8000_0500;
        #1;
        chk("int_flush", {31'b0, bus.exc_flush}, 32'h1);
        chk("int_target", bus.exc_target, 32'hBFC0_0380);
        cyc();
        idle();
        rdreg(5'd13, v);
        chk("int_exccode", {27'b0, v[6:2]}, 32'd0);
        rdreg(5'd14, v);
        chk("int_epc", v, 32'h8000_0500);
        rdreg(5'd12, v);
        chk("int_status", v, 32'h0040_8003);
        chk("int_masked_exl", {31'b0, bus.int_pending}, 32'h0);

        mtc0(5'd11, 32'hFFFF_0000);
        rdreg(5'd13, v);
        chk("compare_clears_ti", {31'b0, v[30]}, 32'h0);

        mtc0(5'd9, 32'h0000_1000);
        rdreg(5'd9, v);
        chk("count_write", v, 32'h0000_1000);

        mtc0(5'd13, 32'hFFFF_FFFF);
        rdreg(5'd13, v);
        chk("cause_ip_sw", {30'b0, v[9:8]}, 32'h3);
        chk("cause_exc_held", {27'b0, v[6:2]}, 32'd0);

        bus.hw_int = 6'b000001;
        cyc();
        rdreg(5'd13, v);
        chk("cause_ip2_hw", {31'b0, v[10]}, 32'h1);
        bus.hw_int = '0;

        // mtc0 EPC not bypassed in the same cycle
        bus.commit_valid = 1'b1;
        bus.cp0_Write = 1'b1;
        bus.cp0_wdata = 32'hA000_0000;
        rdreg(5'd14, v);
        chk("epc_no_bypass", v, 32'h8000_0500);
        cyc();
        idle();
        rdreg(5'd14, v);
        chk("epc_next_cycle", v, 32'hA000_0000);

        // eret drops a same-cycle mtc0
        bus.commit_valid = 1'b1;
        bus.eret = 1'b1;
        bus.cp0_Write = 1'b1;
        bus.cp0_addr = 5'd14;
        bus.cp0_wdata = 32'h1111_1111;
        #1;
        chk("eret3_target", bus.exc_target, 32'hA000_0000);
        cyc();
        idle();
        rdreg(5'd14, v);
        chk("eret_mtc0_dropped", v, 32'hA000_0000);
        rdreg(5'd12, v);
        chk("eret3_status", v, 32'h0040_8001);

        mtc0(5'd12, 32'hFFFF_FFFF);
        rdreg(5'd12, v);
        chk("status_wmask", v, 32'h0040_FF03);
        rdreg(5'd3, v);
        chk("unimpl_reg", v, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
